// File: rtl/reg_arb_pkg.sv
// Shared definitions for the configuration register bank arbiter.
//   AW_DEF / DW_DEF : default address / data widths (256 x 16 bank)
//   arb_state_t     : arbiter FSM state encoding
//   sat_inc16       : saturating 16-bit increment used by the collision counter
package reg_arb_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_A = 2'd1,
    ST_SERVE_B = 2'd2
  } arb_state_t;

  // Holds at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/reg_bank.sv
// Configuration register bank: 2**AW words of DW bits.
// One synchronous write port and one registered read port; the read result
// lands in a per-requester output register so each side's last read data holds
// independently of the other side's traffic. Synchronous reset clears all words.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : write port, committed at the rising edge
//   rd_en/rd_sel_b/rd_addr: read port; rd_sel_b steers the result to rd_data_b
//   rd_data_a, rd_data_b  : registered read data per requester
module reg_bank #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          rd_sel_b,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Storage, write commit and registered read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        if (rd_sel_b) begin
          rd_data_b <= mem[rd_addr];
        end else begin
          rd_data_a <= mem[rd_addr];
        end
      end
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// Arbiter and owner of the shared configuration register bank.
// Serves port A (register-interface master) and port B (two-wire protocol
// engine) one access per cycle, alternating when both are busy. A port-B write
// that collides with a simultaneously granted port-A write to the same address
// is acknowledged with b_drop and discarded.
// Optional build macro: ARB_COLLISION_CNT_EN adds the coll_cnt output.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata           : port A request (level, held until gnt)
//   a_gnt, a_rvalid, a_rdata            : port A grant pulse, read data
//   b_req/b_we/b_addr/b_wdata           : port B request (level, held until gnt)
//   b_gnt, b_drop, b_rvalid, b_rdata    : port B grant pulse, drop flag, read data
//   busy                                : arbiter not idle
//   coll_cnt (ARB_COLLISION_CNT_EN only): saturating count of dropped B writes
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter bit          A_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_drop,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          busy
`ifdef ARB_COLLISION_CNT_EN
  ,
  output logic [15:0]   coll_cnt
`endif
);

  arb_state_t state;
  logic       drop_pending;
  logic       idle_pick_a;
  logic       coll_hit;

  logic          bank_wr_en;
  logic [AW-1:0] bank_wr_addr;
  logic [DW-1:0] bank_wr_data;
  logic          bank_rd_en;
  logic [AW-1:0] bank_rd_addr;

  // Grants, drop flag and busy decode straight from registered state.
  assign a_gnt  = (state == ST_SERVE_A);
  assign b_gnt  = (state == ST_SERVE_B);
  assign b_drop = b_gnt & drop_pending;
  assign busy   = (state != ST_IDLE);

  // Tie-break from IDLE when both ports request.
  assign idle_pick_a = a_req & (~b_req | A_FIRST);

  // Same-address write pair arriving together: A is served first, B loses.
  assign coll_hit = b_req & b_we & a_we & (a_addr == b_addr);

  // Arbiter FSM, collision flag and read-valid pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      drop_pending <= 1'b0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      case (state)
        ST_IDLE: begin
          if (idle_pick_a) begin
            state <= ST_SERVE_A;
            if (coll_hit) begin
              drop_pending <= 1'b1;
            end
          end else if (b_req) begin
            state <= ST_SERVE_B;
          end
        end
        // The granted port's request is still held this cycle and is ignored.
        ST_SERVE_A: state <= b_req ? ST_SERVE_B : ST_IDLE;
        // A B request already in service can never be marked for dropping here.
        ST_SERVE_B: begin
          state        <= a_req ? ST_SERVE_A : ST_IDLE;
          drop_pending <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Access mux into the bank; at most one port is granted per cycle.
  assign bank_wr_en   = (a_gnt & a_we) | (b_gnt & b_we & ~drop_pending);
  assign bank_wr_addr = a_gnt ? a_addr  : b_addr;
  assign bank_wr_data = a_gnt ? a_wdata : b_wdata;
  assign bank_rd_en   = (a_gnt & ~a_we) | (b_gnt & ~b_we);
  assign bank_rd_addr = b_gnt ? b_addr  : a_addr;

  reg_bank #(
    .AW (AW),
    .DW (DW)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bank_wr_en),
    .wr_addr   (bank_wr_addr),
    .wr_data   (bank_wr_data),
    .rd_en     (bank_rd_en),
    .rd_sel_b  (b_gnt),
    .rd_addr   (bank_rd_addr),
    .rd_data_a (a_rdata),
    .rd_data_b (b_rdata)
  );

`ifdef ARB_COLLISION_CNT_EN
  // Count of dropped B writes, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      coll_cnt <= '0;
    end else if (b_drop) begin
      coll_cnt <= sat_inc16(coll_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_reg_arbiter.sv
// Self-checking bench for reg_arbiter: directed scenarios followed by random
// two-port traffic, all checked every cycle against a transaction-level model
// (who is served, a plain memory array, a pending-drop flag).
module tb_reg_arbiter;

  localparam int unsigned AW      = 8;
  localparam int unsigned DW      = 16;
  localparam bit          A_FIRST = 1'b1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_drop, b_rvalid, busy;
  logic [DW-1:0] a_rdata, b_rdata;
`ifdef ARB_COLLISION_CNT_EN
  logic [15:0]   coll_cnt;
`endif

  always #5 clk = ~clk;

  reg_arbiter #(
    .AW (AW), .DW (DW), .A_FIRST (A_FIRST)
  ) dut (
    .clk (clk), .reset (reset),
    .a_req (a_req), .a_we (a_we), .a_addr (a_addr), .a_wdata (a_wdata),
    .a_gnt (a_gnt), .a_rvalid (a_rvalid), .a_rdata (a_rdata),
    .b_req (b_req), .b_we (b_we), .b_addr (b_addr), .b_wdata (b_wdata),
    .b_gnt (b_gnt), .b_drop (b_drop), .b_rvalid (b_rvalid), .b_rdata (b_rdata),
    .busy (busy)
`ifdef ARB_COLLISION_CNT_EN
    , .coll_cnt (coll_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: port served this cycle (0 none, 1 A, 2 B), bank contents,
  // pending B drop, expected read outputs.
  logic [DW-1:0] mem_m [256];
  int            served = 0;
  bit            drop_m = 1'b0;
  logic          ea_rv = 1'b0, eb_rv = 1'b0;
  logic [DW-1:0] ea_rd = '0, eb_rd = '0;
`ifdef ARB_COLLISION_CNT_EN
  logic [15:0]   ecnt = '0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle: retire the access of the cycle just ended, pick the
  // next port from the arbitration rules, then compare every output.
  task automatic step();
    int prev;
    @(posedge clk);
    #1;
    if (reset) begin
      foreach (mem_m[i]) mem_m[i] = '0;
      served = 0;
      drop_m = 1'b0;
      ea_rv  = 1'b0;
      eb_rv  = 1'b0;
      ea_rd  = '0;
      eb_rd  = '0;
`ifdef ARB_COLLISION_CNT_EN
      ecnt   = '0;
`endif
    end else begin
      ea_rv = (served == 1) && !a_we;
      eb_rv = (served == 2) && !b_we;
      if (ea_rv) ea_rd = mem_m[a_addr];
      if (eb_rv) eb_rd = mem_m[b_addr];
      if (served == 1 && a_we) mem_m[a_addr] = a_wdata;
      if (served == 2) begin
        if (drop_m) begin
          drop_m = 1'b0;
`ifdef ARB_COLLISION_CNT_EN
          if (ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
`endif
        end else if (b_we) begin
          mem_m[b_addr] = b_wdata;
        end
      end
      prev = served;
      if (prev == 1)                served = b_req ? 2 : 0;
      else if (prev == 2)           served = a_req ? 1 : 0;
      else if (a_req && b_req)      served = A_FIRST ? 1 : 2;
      else if (a_req)               served = 1;
      else if (b_req)               served = 2;
      else                          served = 0;
      if (prev == 0 && served == 1 && b_req && b_we && a_we && a_addr == b_addr)
        drop_m = 1'b1;
    end
    check_eq("a_gnt",    a_gnt,    served == 1);
    check_eq("b_gnt",    b_gnt,    served == 2);
    check_eq("b_drop",   b_drop,   (served == 2) && drop_m);
    check_eq("busy",     busy,     served != 0);
    check_eq("a_rvalid", a_rvalid, ea_rv);
    check_eq("b_rvalid", b_rvalid, eb_rv);
    check_eq("a_rdata",  a_rdata,  ea_rd);
    check_eq("b_rdata",  b_rdata,  eb_rd);
`ifdef ARB_COLLISION_CNT_EN
    check_eq("coll_cnt", coll_cnt, ecnt);
`endif
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    a_req = req; a_we = we; a_addr = addr; a_wdata = data;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    b_req = req; b_we = we; b_addr = addr; b_wdata = data;
  endtask

  // Small address pool at both ends of the map to provoke collisions and RAW.
  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3))
                                       : AW'($urandom_range(252, 255));
  endfunction

  task automatic rand_a();
    drive_a(1'b1, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
  endtask

  task automatic rand_b();
    drive_b(1'b1, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
  endtask

  initial begin
    bit a_hold, b_hold;
    int ia, ib, ga, gb, first, last, prev_g, alt_bad;

    // Reset state.
    step(); step();
    reset = 1'b0;
    step();

    // 1: A write 0x12 <- BEEF, then A read 0x12.
    drive_a(1'b1, 1'b1, 8'h12, 16'hBEEF);
    step();                                   // grant one cycle after request
    check_eq("t1_wr_gnt", a_gnt, 1'b1);
    step();
    drive_a(1'b1, 1'b0, 8'h12, 16'h0000);
    step();
    check_eq("t1_rd_gnt", a_gnt, 1'b1);
    step();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("t1_rvalid", a_rvalid, 1'b1);
    check_eq("t1_rdata", a_rdata, 16'hBEEF);
    check_eq("t1_b_idle", b_gnt | b_rvalid, 1'b0);
    step();

    // 2: simultaneous reads, A wins the tie.
    drive_a(1'b1, 1'b0, 8'h05, 16'h0000);
    drive_b(1'b1, 1'b0, 8'h06, 16'h0000);
    step();
    check_eq("t2_a_first", {a_gnt, b_gnt, busy}, 3'b101);
    step();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("t2_b_second", {a_gnt, b_gnt, busy, a_rvalid}, 4'b0111);
    step();
    drive_b(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("t2_b_rvalid", {b_rvalid, busy}, 2'b10);
    step();

    // 3: both ports keep requesting, 8 accesses each.
    drive_a(1'b1, 1'b0, 8'h10, 16'h0000);
    drive_b(1'b1, 1'b1, 8'h20, 16'h0101);
    ia = 1; ib = 1; a_hold = 0; b_hold = 0;
    ga = 0; gb = 0; first = -1; last = -1; prev_g = 0; alt_bad = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (a_gnt || b_gnt) begin
        if (first < 0) first = c;
        last = c;
      end
      if (a_gnt) begin ga++; if (prev_g == 1) alt_bad++; prev_g = 1; end
      if (b_gnt) begin gb++; if (prev_g == 2) alt_bad++; prev_g = 2; end
      if (a_hold) begin
        a_hold = 0;
        if (ia < 8) begin rand_a(); ia++; end else a_req = 1'b0;
      end
      if (b_hold) begin
        b_hold = 0;
        if (ib < 8) begin rand_b(); ib++; end else b_req = 1'b0;
      end
      if (served == 1) a_hold = 1;
      if (served == 2) b_hold = 1;
    end
    check_eq("t3_a_gnts", ga, 8);
    check_eq("t3_b_gnts", gb, 8);
    check_eq("t3_alt_breaks", alt_bad, 0);
    check_eq("t3_span", last - first + 1, 16);

    // 4: same-address write collision, B dropped.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive_a(1'b1, 1'b1, 8'h80, 16'h1111);
    drive_b(1'b1, 1'b1, 8'h80, 16'h2222);
    step();
    step();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("t4_b_drop", {b_gnt, b_drop}, 2'b11);
    step();
    drive_b(1'b0, 1'b0, 8'h00, 16'h0000);
    drive_a(1'b1, 1'b0, 8'h80, 16'h0000);
    step();
    step();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("t4_rdata", a_rdata, 16'h1111);
`ifdef ARB_COLLISION_CNT_EN
    check_eq("t4_coll_cnt", coll_cnt, 16'd1);
`endif
    step();

    // 5: adjacent-address writes, no drop.
    drive_a(1'b1, 1'b1, 8'h80, 16'h1111);
    drive_b(1'b1, 1'b1, 8'h81, 16'h2222);
    step();
    step();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("t5_no_drop", {b_gnt, b_drop}, 2'b10);
    step();
    drive_b(1'b0, 1'b0, 8'h00, 16'h0000);
    drive_a(1'b1, 1'b0, 8'h80, 16'h0000);
    drive_b(1'b1, 1'b0, 8'h81, 16'h0000);
    step();
    step();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("t5_a_rdata", a_rdata, 16'h1111);
    step();
    drive_b(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("t5_b_rdata", b_rdata, 16'h2222);
    step();

    // 6: reset during a B write aborts it and clears the bank.
    drive_a(1'b1, 1'b1, 8'h40, 16'hABCD);
    step();
    step();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0000);
    drive_b(1'b1, 1'b1, 8'h40, 16'h5555);
    step();
    check_eq("t6_b_gnt", b_gnt, 1'b1);
    reset = 1'b1;
    step();
    check_eq("t6_abort", {a_gnt, b_gnt, a_rvalid, b_rvalid}, 4'b0000);
    reset = 1'b0;
    drive_b(1'b0, 1'b0, 8'h00, 16'h0000);
    step();
    drive_a(1'b1, 1'b0, 8'h40, 16'h0000);
    step();
    step();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("t6_rdata", {a_rvalid, a_rdata}, {1'b1, 16'h0000});
    step();

    // Random traffic with occasional resets.
    a_hold = 0; b_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        drive_a(1'b0, 1'b0, 8'h00, 16'h0000);
        drive_b(1'b0, 1'b0, 8'h00, 16'h0000);
        a_hold = 0; b_hold = 0;
        continue;
      end
      if (a_hold) begin
        a_hold = 0;
        if ($urandom_range(0, 3) != 0) rand_a(); else a_req = 1'b0;
      end else if (!a_req && $urandom_range(0, 2) == 0) begin
        rand_a();
      end
      if (b_hold) begin
        b_hold = 0;
        if ($urandom_range(0, 3) != 0) rand_b(); else b_req = 1'b0;
      end else if (!b_req && $urandom_range(0, 2) == 0) begin
        rand_b();
      end
      if (served == 1) a_hold = 1;
      if (served == 2) b_hold = 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
